// File: rtl/mat_mult_core.sv
// mat_mult_core: streams in square matrices A and B, computes C = A x B one MAC per cycle, streams C out.
// Define MM_SIGNED_EN for two's-complement elements and signed results; default is unsigned.
module mat_mult_core #(
    parameter int N = 2,
    parameter int W = 4,
    localparam int OW = 2 * W + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LN = CW'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

    state_t        state;
    logic [W-1:0]  a [N][N];
    logic [W-1:0]  b [N][N];
    logic [OW-1:0] cm [N][N];
    logic [CW-1:0] r, c, k, nr, nc;
    logic [OW-1:0] acc, ea, eb, prod, sum;
    logic          mac_done, last_rc, in_hs;

    // r/c walk row-major in every phase; k is the inner-product index during COMPUTE
    assign nc      = (c == LN) ? '0 : c + 1'b1;
    assign nr      = (c != LN) ? r : (r == LN) ? '0 : r + 1'b1;
    assign last_rc = (r == LN) && (c == LN);
    assign in_hs   = in_valid && in_ready;
    assign busy    = (state == COMPUTE) || (state == OUTPUT);

`ifdef MM_SIGNED_EN
    assign ea = {{(OW-W){a[r][k][W-1]}}, a[r][k]};
    assign eb = {{(OW-W){b[k][c][W-1]}}, b[k][c]};
`else
    assign ea = {{(OW-W){1'b0}}, a[r][k]};
    assign eb = {{(OW-W){1'b0}}, b[k][c]};
`endif
    // OW-bit product is exact modulo 2^OW, which is all a two's-complement or unsigned sum needs
    assign prod = ea * eb;
    assign sum  = ((k == '0) ? '0 : acc) + prod;

    always_ff @(posedge clk) begin
        if (!clr && in_hs && state == LOAD_A) a[r][c] <= in_data;
        if (!clr && in_hs && state == LOAD_B) b[r][c] <= in_data;
        if (!clr && state == COMPUTE && !mac_done && k == LN) cm[r][c] <= sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            acc       <= '0;
            mac_done  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            state     <= LOAD_A;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            acc       <= '0;
            mac_done  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        r <= nr;
                        c <= nc;
                        if (last_rc) begin
                            state    <= (state == LOAD_A) ? LOAD_B : COMPUTE;
                            in_ready <= (state == LOAD_A);
                        end
                    end
                end
                COMPUTE: begin
                    if (!mac_done) begin
                        acc <= sum;
                        if (k == LN) begin
                            k        <= '0;
                            r        <= nr;
                            c        <= nc;
                            mac_done <= last_rc;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        state     <= OUTPUT;
                        mac_done  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= cm[0][0];
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r <= nr;
                        c <= nc;
                        if (last_rc) begin
                            state     <= LOAD_A;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_data <= cm[nr][nc];
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_mult_core.sv
// tb_mat_mult_core: directed vectors for mat_mult_core at N=2, W=4 (OW=9).
module tb_mat_mult_core;
    localparam int N = 2;
    localparam int W = 4;
    localparam int OW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, busy;
    logic [OW-1:0] out_data;
    int            checks = 0;
    int            errors = 0;
    bit            noise = 1'b0;

    always #5 clk = ~clk;

    mat_mult_core #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // am/bm hold four nibbles, first element in the top nibble
    task automatic load(input logic [15:0] am, input logic [15:0] bm, input int nb = 8);
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_data  = (i < 4) ? am[15-4*i -: 4] : bm[15-4*(i-4) -: 4];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        chk({tag, "_busy"}, busy, 1);
        while (!out_valid && n < 100) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 4'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, n, 9);
    endtask

    task automatic drain(input string tag, input int c0, input int c1, input int c2, input int c3);
        int e[4];
        e = '{c0, c1, c2, c3};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_c%0d", tag, i), out_data, e[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_ready"}, in_ready, 1);
        chk({tag, "_done_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        load(16'h1234, 16'h5678);
        wait_valid("basic");
        drain("basic", 19, 22, 43, 50);

        load(16'h1234, 16'h5678);
        wait_valid("bp");
        repeat (5) @(negedge clk);
        chk("bp_hold_data", out_data, 19);
        chk("bp_hold_valid", out_valid, 1);
        drain("bp", 19, 22, 43, 50);

        load(16'hF00F, 16'h3003);
        wait_valid("sgn");
`ifdef MM_SIGNED_EN
        drain("sgn", 'h1FD, 0, 0, 'h1FD);
`else
        drain("sgn", 45, 0, 0, 45);
`endif

        load(16'h1111, 16'h9999, 7);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h9;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", in_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_out_valid", out_valid, 0);
        load(16'h2013, 16'h1201);
        wait_valid("clr");
        drain("clr", 2, 4, 1, 5);

        noise = 1'b1;
        load(16'h1234, 16'h5678);
        wait_valid("noise");
        noise = 1'b0;
        drain("noise", 19, 22, 43, 50);

        load(16'hFFFF, 16'hFFFF);
        wait_valid("max");
        chk("max_c0", out_data, 450);
        out_ready = 1'b1;
        @(negedge clk);
        chk("max_c1", out_data, 450);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid_after", out_valid, 0);
        load(16'hFFFF, 16'hFFFF);
        wait_valid("max2");
        drain("max2", 450, 450, 450, 450);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
